// File: rtl/remote_pkg.sv
// Shared constants and types for the remote command receiver.
package remote_pkg;

    localparam logic [7:0] REMOTE_HDR = 8'hA5;
    localparam logic [2:0] MAX_ACC    = 3'd4;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_CHK
    } pkt_state_t;

    typedef struct packed {
        logic       car_sel;
        logic [1:0] rsvd;
        logic [2:0] acc;
        logic [1:0] omega;
    } cmd_data_t;

    // A data/checksum pair is usable when the checksum is the inverted data,
    // the reserved bits are clear and the acceleration is in range.
    function automatic logic cmd_ok(input logic [7:0] d_raw, input logic [7:0] chk);
        cmd_data_t d;
        d = d_raw;
        return (chk == ~d_raw) && (d.rsvd == 2'b00) && (d.acc <= MAX_ACC);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver working on an already synchronized rx line.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t      state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           rx_prev;

    // Bit-timing state machine: find a falling edge, confirm the start bit at
    // mid-bit, then take each data bit and the stop bit one bit period apart.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_prev      <= 1'b1;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            rx_prev      <= i_rx;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !i_rx) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= i_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shift <= {i_rx, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (i_rx) begin
                            o_byte       <= shift;
                            o_byte_valid <= 1'b1;
                        end else begin
                            o_frame_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/remote_cmd_rx.sv
// Remote control packet receiver: decodes A5/D/~D packets into per-car
// acceleration and steering commands with a per-car link timeout.
module remote_cmd_rx
    import remote_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int GAP_CYCLES     = 4 * 10 * CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [2:0] o_car1_acc,
    output logic [2:0] o_car2_acc,
    output logic [1:0] o_car1_omega,
    output logic [1:0] o_car2_omega,
    output logic       o_pkt_valid,
    output logic       o_err,
    output logic [1:0] o_link_up
);

    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_SAT   = GW'(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;
    pkt_state_t    state;
    logic [7:0]    data_q;
    cmd_data_t     cmd;
    logic [GW-1:0] gap_cnt;
    logic          accept;
    logic [2:0]    acc_q   [2];
    logic [1:0]    omega_q [2];
    logic [TW-1:0] to_cnt  [2];
    logic [1:0]    link_q;

    // Two-flop synchronizer for the asynchronous rx line; idles high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
        end
    end

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (sync_q[1]),
        .o_byte       (rx_byte),
        .o_byte_valid (rx_valid),
        .o_frame_err  (rx_ferr)
    );

    assign cmd    = data_q;
    assign accept = rx_valid && (state == S_CHK) && cmd_ok(data_q, rx_byte);

    // Packet framing: header, data, checksum, with framing and inter-byte
    // gap errors forcing a resync to the header state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_HDR;
            data_q      <= '0;
            gap_cnt     <= '0;
            o_pkt_valid <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_pkt_valid <= 1'b0;
            o_err       <= 1'b0;
            if (rx_valid || rx_ferr) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_SAT) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
            if (rx_ferr) begin
                o_err <= 1'b1;
                state <= S_HDR;
            end else if (rx_valid) begin
                case (state)
                    S_HDR: begin
                        if (rx_byte == REMOTE_HDR) begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        data_q <= rx_byte;
                        state  <= S_CHK;
                    end
                    S_CHK: begin
                        if (accept) begin
                            o_pkt_valid <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                        state <= S_HDR;
                    end
                    default: state <= S_HDR;
                endcase
            end else if ((state != S_HDR) && (gap_cnt > GAP_LIMIT)) begin
                o_err <= 1'b1;
                state <= S_HDR;
            end
        end
    end

    // Per-car command registers and link timeout; a fresh packet beats expiry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < 2; n++) begin
                acc_q[n]   <= '0;
                omega_q[n] <= '0;
                to_cnt[n]  <= TO_MAX;
            end
            link_q <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (accept && (cmd.car_sel == 1'(n))) begin
                    acc_q[n]   <= cmd.acc;
                    omega_q[n] <= cmd.omega;
                    link_q[n]  <= 1'b1;
                    to_cnt[n]  <= '0;
                end else if (to_cnt[n] != TO_MAX) begin
                    to_cnt[n] <= to_cnt[n] + TW'(1);
                    if (to_cnt[n] == TO_LAST) begin
                        acc_q[n]   <= '0;
                        omega_q[n] <= '0;
                        link_q[n]  <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_car1_acc   = acc_q[0];
    assign o_car2_acc   = acc_q[1];
    assign o_car1_omega = omega_q[0];
    assign o_car2_omega = omega_q[1];
    assign o_link_up    = link_q;

endmodule

// File: doc/remote_cmd_rx.md
REMOTE_CMD_RX -- requirements
Module: remote_cmd_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clocks per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 5_000_000, giving clocks without a valid packet per car before failsafe.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 4*10*CLKS_PER_BIT, giving the maximum idle clocks between bytes of one packet.
REQ-004 The ports SHALL be, clock and reset first:
 i_clk  in  1  system clock
 i_rst  in  1  reset, asynchronous, active-high
 i_rx  in  1  UART line from remote, idle high, async to i_clk
 o_car1_acc  out  3  car 1 acceleration command, 0..4
 o_car2_acc  out  3  car 2 acceleration command, 0..4
 o_car1_omega  out  2  car 1 steering command
 o_car2_omega  out  2  car 2 steering command
 o_pkt_valid  out  1  one-cycle pulse on each accepted packet
 o_err  out  1  one-cycle pulse on framing, checksum, range or gap error
 o_link_up  out  2  bit n-1 high while car n is inside its timeout window
REQ-005 The design SHALL use one clock domain, i_clk; the reset is asynchronous and active-high, named i_rst.

Function
REQ-006 i_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-007 The byte receiver SHALL detect a start bit on a high-to-low transition of synchronized rx, recheck it low at CLKS_PER_BIT/2, then sample 8 data bits LSB first and the stop bit, each CLKS_PER_BIT apart.
REQ-008 A start bit found high at mid-bit SHALL be discarded silently, with the receiver returning to idle.
REQ-009 A stop bit sampled low SHALL be a framing error: o_err pulses, the byte is dropped, and the packet FSM returns to S_HDR.
REQ-010 A packet SHALL be three bytes: header 8'hA5, data byte D, checksum C = D ^ 8'hFF.
REQ-011 D fields SHALL be: [7] car select (0 = car1, 1 = car2), [6:5] reserved and must be 0, [4:2] acc, [1:0] omega.
REQ-012 The packet FSM states SHALL be S_HDR, S_DATA, S_CHK.
REQ-013 In S_HDR, a byte equal to 8'hA5 SHALL move the FSM to S_DATA; any other byte SHALL be ignored without an error.
REQ-014 In S_DATA, any byte SHALL be stored as D and move the FSM to S_CHK.
REQ-015 In S_CHK, the packet SHALL be accepted only if C matches, D[6:5] = 0 and acc <= 4; otherwise o_err pulses; either way the FSM returns to S_HDR.
REQ-016 An accepted packet SHALL update only the selected car's acc and omega, pulse o_pkt_valid, and reload that car's timeout counter, all on the clock after the stop-bit sample of C.
REQ-017 In S_DATA or S_CHK, more than GAP_CYCLES since the previous byte's stop bit SHALL pulse o_err and return the FSM to S_HDR.
REQ-018 Each car's timeout counter SHALL saturate at TIMEOUT_CYCLES; on reaching it, that car's acc and omega SHALL become 0 and its o_link_up bit SHALL go low.
REQ-019 An acceptance in the same cycle as timeout expiry SHALL win: new values are applied and the counter is reloaded.
REQ-020 o_pkt_valid and o_err SHALL never be high in the same cycle.

Reset
REQ-021 While i_rst is high, all outputs SHALL be 0, the FSM SHALL be in S_HDR, the byte receiver SHALL be idle, the synchronizer flops SHALL be 1, and the timeout counters SHALL be at TIMEOUT_CYCLES.
REQ-022 Assertion of i_rst mid-byte or mid-packet SHALL abandon the partial data, with no o_err pulse.

Structure
REQ-023 Package remote_pkg SHALL hold REMOTE_HDR = 8'hA5, MAX_ACC = 3'd4, the packet-FSM state enum, and a packed struct for D.
REQ-024 The byte receiver SHALL be the sub-module uart_rx_byte, with outputs o_byte[7:0], o_byte_valid pulse and o_frame_err pulse.

Verification (bench CLKS_PER_BIT=8, TIMEOUT_CYCLES=2000, GAP_CYCLES=320)
REQ-025 Send A5,10,EF -> o_pkt_valid pulse; o_car1_acc=4, o_car1_omega=0; car2 outputs unchanged at 0; o_link_up=2'b01.
REQ-026 Send A5,8E,71 -> o_car2_acc=3, o_car2_omega=2; then send A5,8E,70 -> o_err pulse and car2 still at 3/2.
REQ-027 Send A5,14,EB (acc=5) -> o_err pulse; car1 unchanged.
REQ-028 Send 00,A5,10 followed by a stop bit forced low on EF -> one o_err pulse only; the next clean A5,10,EF is accepted.
REQ-029 After car1 reaches acc=4, stop sending for 2000 cycles -> o_car1_acc=0 and o_link_up[0]=0 at cycle 2000.
REQ-030 Send A5, then idle 400 cycles, then 10,EF -> o_err pulse from the gap; the 10 and EF bytes are ignored and no o_pkt_valid pulse occurs.
